// File: rtl/riscv_dmem_pkg.sv
// Shared constants for the riscv_dmem_slave data-side responder.
// Holds the MMIO map, the STATUS register layout and the default window base.
package riscv_dmem_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

    localparam logic [11:0] OFF_CYCLE  = 12'h000;
    localparam logic [11:0] OFF_TXDATA = 12'h004;
    localparam logic [11:0] OFF_STATUS = 12'h008;
    localparam logic [11:0] OFF_CLR    = 12'h00C;

    localparam int unsigned ST_EMPTY_BIT = 0;
    localparam int unsigned ST_FULL_BIT  = 1;
    localparam int unsigned ST_OVF_BIT   = 2;
    localparam int unsigned ST_COUNT_LSB = 8;

    // Matches the bit positions above.
    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  count;
        logic [4:0]  rsvd_lo;
        logic        ovf;
        logic        full;
        logic        empty;
    } status_t;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO with registered occupancy; head is not fall-through.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module riscv_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage is not reset; emptiness gates the head output.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_dmem_slave.sv
// Data-port responder for riscv_core: word RAM at 0 plus an MMIO window with
// a free-running cycle counter and a byte-wide debug output FIFO.
module riscv_dmem_slave
    import riscv_dmem_pkg::*;
#(
    parameter int unsigned RAM_DEPTH  = 1024,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        rd_en_i,
    input  logic        wr_en_i,
    output logic        dbg_valid_o,
    output logic [7:0]  dbg_data_o,
    input  logic        dbg_ready_i
);

    localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       r_ram [RAM_DEPTH];
    logic [31:0]       r_cycle;
    logic              r_ovf;

    logic              w_ram_hit;
    logic              w_mmio_hit;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [9:0]        w_word;
    logic              w_sel_cycle;
    logic              w_sel_tx;
    logic              w_sel_status;
    logic              w_sel_clr;
    logic              w_tx_push;
    logic              w_pop;
    logic              w_overflow;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    status_t           w_status;
    logic              w_unused_addr;

    // Byte-lane bits carry no meaning on this word-only port.
    assign w_unused_addr = ^addr_i[1:0];

    assign w_ram_hit    = (addr_i[31:RAM_AW+2] == '0);
    assign w_mmio_hit   = (addr_i[31:12] == MMIO_BASE[31:12]);
    assign w_ram_idx    = addr_i[RAM_AW+1:2];
    assign w_word       = addr_i[11:2];
    assign w_sel_cycle  = w_mmio_hit && (w_word == OFF_CYCLE[11:2]);
    assign w_sel_tx     = w_mmio_hit && (w_word == OFF_TXDATA[11:2]);
    assign w_sel_status = w_mmio_hit && (w_word == OFF_STATUS[11:2]);
    assign w_sel_clr    = w_mmio_hit && (w_word == OFF_CLR[11:2]);

    assign w_tx_push  = wr_en_i && w_sel_tx;
    assign w_pop      = dbg_valid_o && dbg_ready_i;
    assign w_overflow = w_tx_push && w_full && !w_pop;

    riscv_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_dbg_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_tx_push),
        .i_data  (wdata_i[7:0]),
        .i_pop   (w_pop),
        .o_data  (dbg_data_o),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign dbg_valid_o = !w_empty;

    // RAM keeps its contents across reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && w_ram_hit) begin
            r_ram[w_ram_idx] <= wdata_i;
        end
    end

    // A software load replaces the increment for that cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cycle <= '0;
        end else if (wr_en_i && w_sel_cycle) begin
            r_cycle <= wdata_i;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // Overflow wins over a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (w_overflow) begin
            r_ovf <= 1'b1;
        end else if (wr_en_i && w_sel_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_status       = '0;
        w_status.empty = w_empty;
        w_status.full  = w_full;
        w_status.ovf   = r_ovf;
        w_status.count = 8'(w_count);
    end

    // Zero-latency read path; the core registers rdata_o into MEM/WB.
    always_comb begin
        rdata_o = '0;
        if (rd_en_i) begin
            if (w_ram_hit) begin
                rdata_o = r_ram[w_ram_idx];
            end else if (w_sel_cycle) begin
                rdata_o = r_cycle;
            end else if (w_sel_status) begin
                rdata_o = w_status;
            end
        end
    end

endmodule

// File: tb/tb_riscv_dmem_slave.sv
// Self-checking bench for riscv_dmem_slave; debug FIFO bytes are tracked in a
// scoreboard queue filled on push and drained as the DUT presents them.
module tb_riscv_dmem_slave;

    localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
    localparam logic [31:0] A_TX     = 32'h8000_0004;
    localparam logic [31:0] A_STATUS = 32'h8000_0008;
    localparam logic [31:0] A_CLR    = 32'h8000_000C;
    localparam int          DEPTH    = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        rd_en_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic        dbg_valid_o;
    logic [7:0]  dbg_data_o;
    logic        dbg_ready_i = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];

    riscv_dmem_slave dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .rd_en_i     (rd_en_i),
        .wr_en_i     (wr_en_i),
        .dbg_valid_o (dbg_valid_o),
        .dbg_data_o  (dbg_data_o),
        .dbg_ready_i (dbg_ready_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk_i);
        rst_i   = 1'b1;
        rd_en_i = 1'b0;
        wr_en_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_i);
        addr_i  = a;
        wdata_i = d;
        wr_en_i = 1'b1;
        rd_en_i = 1'b0;
        @(posedge clk_i);
        #1 wr_en_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk_i);
        addr_i  = a;
        rd_en_i = 1'b1;
        wr_en_i = 1'b0;
        #1 d = rdata_o;
        @(posedge clk_i);
        #1 rd_en_i = 1'b0;
    endtask

    // Stimulus only: push a byte while the consumer is stalled, model drops on full.
    task automatic push_byte(input logic [7:0] b);
        wr(A_TX, {24'h0, b});
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        @(negedge clk_i);
        addr_i = A_CYCLE;
        #1;
        n_checks++;
        if (rdata_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_rdata_idle: got %h want %h", rdata_o, 32'h0);
        end
        n_checks++;
        if (dbg_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid: got %b want 0", dbg_valid_o);
        end
        n_checks++;
        if (dbg_data_o !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_data: got %h want 00", dbg_data_o);
        end
        rd(A_STATUS, v);
        n_checks++;
        if (v !== 32'h0000_0001) begin
            n_errors++;
            $display("FAIL reset_status: got %h want %h", v, 32'h0000_0001);
        end
    endtask

    task automatic test_ram();
        logic [31:0] v;
        wr(32'h10, 32'hDEAD_BEEF);
        wr(32'h14, 32'h0BAD_F00D);
        rd(32'h10, v);
        n_checks++;
        if (v !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL ram_read_0x10: got %h want %h", v, 32'hDEAD_BEEF);
        end
        rd(32'h13, v);
        n_checks++;
        if (v !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL ram_read_0x13: got %h want %h", v, 32'hDEAD_BEEF);
        end
        rd(32'hFFC, v);
        wr(32'hFFC, 32'h5A5A_0FFC);
        rd(32'hFFC, v);
        n_checks++;
        if (v !== 32'h5A5A_0FFC) begin
            n_errors++;
            $display("FAIL ram_top_word: got %h want %h", v, 32'h5A5A_0FFC);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] v;
        wr(32'h0, 32'hCAFE_0000);
        wr(32'h4000_0000, 32'h0000_1234);
        rd(32'h4000_0000, v);
        n_checks++;
        if (v !== 32'h0) begin
            n_errors++;
            $display("FAIL unmapped_read: got %h want %h", v, 32'h0);
        end
        wr(32'h1000, 32'h7777_7777);
        rd(32'h0, v);
        n_checks++;
        if (v !== 32'hCAFE_0000) begin
            n_errors++;
            $display("FAIL ram_word0_intact: got %h want %h", v, 32'hCAFE_0000);
        end
        rd(32'h8000_0010, v);
        n_checks++;
        if (v !== 32'h0) begin
            n_errors++;
            $display("FAIL mmio_other_offset: got %h want %h", v, 32'h0);
        end
    endtask

    task automatic test_cycle();
        logic [31:0] v;
        do_reset();
        repeat (5) @(posedge clk_i);
        rd(A_CYCLE, v);
        n_checks++;
        if (v !== 32'd5) begin
            n_errors++;
            $display("FAIL cycle_after_reset: got %0d want 5", v);
        end
        wr(A_CYCLE, 32'hFFFF_FFFE);
        rd(A_CYCLE, v);
        n_checks++;
        if (v !== 32'hFFFF_FFFE) begin
            n_errors++;
            $display("FAIL cycle_load: got %h want %h", v, 32'hFFFF_FFFE);
        end
        rd(A_CYCLE, v);
        n_checks++;
        if (v !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL cycle_inc: got %h want %h", v, 32'hFFFF_FFFF);
        end
        rd(A_CYCLE, v);
        n_checks++;
        if (v !== 32'h0) begin
            n_errors++;
            $display("FAIL cycle_wrap: got %h want %h", v, 32'h0);
        end
    endtask

    // Pop every queued byte with ready held high, comparing against the scoreboard.
    task automatic drain(input string tag);
        logic [7:0] e;
        int n;
        n = exp_q.size();
        @(negedge clk_i);
        dbg_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if (dbg_valid_o !== 1'b1 || dbg_data_o !== e) begin
                n_errors++;
                $display("FAIL %s_byte%0d: got valid=%b data=%h want valid=1 data=%h",
                         tag, i, dbg_valid_o, dbg_data_o, e);
            end
            @(negedge clk_i);
        end
        dbg_ready_i = 1'b0;
        #1;
        n_checks++;
        if (dbg_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_empty_valid: got %b want 0", tag, dbg_valid_o);
        end
    endtask

    task automatic test_fifo();
        logic [31:0] v;
        do_reset();
        @(negedge clk_i);
        addr_i  = A_TX;
        wdata_i = 32'h0000_0041;
        wr_en_i = 1'b1;
        exp_q.push_back(8'h41);
        #1;
        n_checks++;
        if (dbg_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL fifo_no_fallthrough: got %b want 0", dbg_valid_o);
        end
        @(posedge clk_i);
        #1 wr_en_i = 1'b0;
        n_checks++;
        if (dbg_valid_o !== 1'b1 || dbg_data_o !== 8'h41) begin
            n_errors++;
            $display("FAIL fifo_first_head: got valid=%b data=%h want valid=1 data=41",
                     dbg_valid_o, dbg_data_o);
        end
        push_byte(8'h42);
        push_byte(8'h43);
        rd(A_STATUS, v);
        n_checks++;
        if (v !== 32'h0000_0300) begin
            n_errors++;
            $display("FAIL fifo_status3: got %h want %h", v, 32'h0000_0300);
        end
        n_checks++;
        if (dbg_data_o !== 8'h41) begin
            n_errors++;
            $display("FAIL fifo_head_stable: got %h want 41", dbg_data_o);
        end
        drain("fifo");
        rd(A_STATUS, v);
        n_checks++;
        if (v !== 32'h0000_0001) begin
            n_errors++;
            $display("FAIL fifo_status_empty: got %h want %h", v, 32'h0000_0001);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        do_reset();
        for (int i = 0; i < 9; i++) push_byte(8'h60 + 8'(i));
        rd(A_STATUS, v);
        n_checks++;
        if (v !== 32'h0000_0806) begin
            n_errors++;
            $display("FAIL ovf_status: got %h want %h", v, 32'h0000_0806);
        end
        wr(A_CLR, 32'h0);
        rd(A_STATUS, v);
        n_checks++;
        if (v !== 32'h0000_0802) begin
            n_errors++;
            $display("FAIL ovf_clear: got %h want %h", v, 32'h0000_0802);
        end
        rd(A_TX, v);
        n_checks++;
        if (v !== 32'h0) begin
            n_errors++;
            $display("FAIL txdata_read: got %h want %h", v, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        // FIFO is full from the overflow scenario: push and pop together.
        @(negedge clk_i);
        dbg_ready_i = 1'b1;
        addr_i      = A_TX;
        wdata_i     = 32'h0000_0099;
        wr_en_i     = 1'b1;
        #1;
        n_checks++;
        if (dbg_valid_o !== 1'b1 || dbg_data_o !== exp_q[0]) begin
            n_errors++;
            $display("FAIL full_pushpop_head: got %h want %h", dbg_data_o, exp_q[0]);
        end
        @(posedge clk_i);
        #1;
        wr_en_i     = 1'b0;
        dbg_ready_i = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h99);
        rd(A_STATUS, v);
        n_checks++;
        if (v !== 32'h0000_0802) begin
            n_errors++;
            $display("FAIL full_pushpop_status: got %h want %h", v, 32'h0000_0802);
        end
        drain("b2b");
        // Same-cycle load and store returns the old word.
        wr(32'h20, 32'h1111_1111);
        @(negedge clk_i);
        addr_i  = 32'h20;
        wdata_i = 32'h2222_2222;
        rd_en_i = 1'b1;
        wr_en_i = 1'b1;
        #1;
        n_checks++;
        if (rdata_o !== 32'h1111_1111) begin
            n_errors++;
            $display("FAIL rw_same_cycle: got %h want %h", rdata_o, 32'h1111_1111);
        end
        @(posedge clk_i);
        #1;
        rd_en_i = 1'b0;
        wr_en_i = 1'b0;
        rd(32'h20, v);
        n_checks++;
        if (v !== 32'h2222_2222) begin
            n_errors++;
            $display("FAIL rw_commit: got %h want %h", v, 32'h2222_2222);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        wr(32'h40, 32'hA5A5_A5A5);
        push_byte(8'h31);
        push_byte(8'h32);
        push_byte(8'h33);
        do_reset();
        #1;
        n_checks++;
        if (dbg_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_valid: got %b want 0", dbg_valid_o);
        end
        rd(A_CYCLE, v);
        n_checks++;
        if (v !== 32'h0) begin
            n_errors++;
            $display("FAIL rstmid_cycle: got %h want %h", v, 32'h0);
        end
        rd(A_STATUS, v);
        n_checks++;
        if (v !== 32'h0000_0001) begin
            n_errors++;
            $display("FAIL rstmid_status: got %h want %h", v, 32'h0000_0001);
        end
        rd(32'h40, v);
        n_checks++;
        if (v !== 32'hA5A5_A5A5) begin
            n_errors++;
            $display("FAIL rstmid_ram: got %h want %h", v, 32'hA5A5_A5A5);
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_unmapped();
        test_cycle();
        test_fifo();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
